// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the player-code path between player_input_encoder
// and state_machine.
//   CODE_W / CODE_NONE : width and idle value of a player action code
//   player_state_e     : player FSM states
//   lowest_index()     : index of the lowest set bit of a button vector
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } player_state_e;

    // Buttons are zero-extended to 7 bits by the caller, so a code of
    // index+1 always fits in CODE_W bits. Scanning from the top down makes
    // the lowest set bit the final winner.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [6:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 6; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/player_input_encoder_if.sv
// ---------------------------------------------------------------------------
// player_input_encoder_if
// Board-side inputs and registered player-code outputs of the encoder.
//   enable         : 1 = accept player actions
//   btn_start_raw  : raw start button (asynchronous, active-high)
//   btn_p1_raw/p2  : raw player buttons (asynchronous, active-high)
//   start          : one-cycle pulse on debounced start press
//   p1/p2          : player action codes (0 = none, else button index+1)
//   p1_new/p2_new  : one-cycle pulse when a new nonzero code appears
// master = encoder (producer), slave = consumer / board side.
// ---------------------------------------------------------------------------
interface player_input_encoder_if
    import game_pkg::*;
#(
    parameter int NUM_BTN = 5
);

    logic                enable;
    logic                btn_start_raw;
    logic [NUM_BTN-1:0]  btn_p1_raw;
    logic [NUM_BTN-1:0]  btn_p2_raw;
    logic                start;
    logic [CODE_W-1:0]   p1;
    logic [CODE_W-1:0]   p2;
    logic                p1_new;
    logic                p2_new;

    modport master (
        input  enable, btn_start_raw, btn_p1_raw, btn_p2_raw,
        output start, p1, p2, p1_new, p2_new
    );

    modport slave (
        output enable, btn_start_raw, btn_p1_raw, btn_p2_raw,
        input  start, p1, p2, p1_new, p2_new
    );

endinterface

// File: rtl/player_input_encoder_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a stable-run counter. The output level
// only changes after the synchronized input has disagreed with it for
// DEB_CYCLES consecutive cycles.
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : debounced level
// ---------------------------------------------------------------------------
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Any agreeing cycle restarts the run; the level flips on the same edge
    // the run completes, so latency is 2 sync cycles + DEB_CYCLES.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_inc == CNT_DONE) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/player_input_encoder.sv
// ---------------------------------------------------------------------------
// player_input_encoder
// Turns bouncing player buttons and the start button into clean registered
// action codes and a start pulse for state_machine.
//   clk, rst : clock, synchronous active-high reset
//   bus      : player_input_encoder_if.master (enable, raw buttons in;
//              start, p1, p2, p1_new, p2_new out)
// ---------------------------------------------------------------------------
module player_input_encoder
    import game_pkg::*;
#(
    parameter int NUM_BTN    = 5,
    parameter int DEB_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    player_input_encoder_if.master  bus
);

    localparam int NUM_IN = 2 * NUM_BTN + 1;

    // Bit layout: [NUM_BTN-1:0] player 1, next NUM_BTN player 2, top bit start.
    logic [NUM_IN-1:0] raw_all;
    logic [NUM_IN-1:0] deb_all;

    assign raw_all = {bus.btn_start_raw, bus.btn_p2_raw, bus.btn_p1_raw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (raw_all[i]),
            .dout (deb_all[i])
        );
    end

    logic [NUM_BTN-1:0] deb_btn [2];
    assign deb_btn[0] = deb_all[NUM_BTN-1:0];
    assign deb_btn[1] = deb_all[2*NUM_BTN-1:NUM_BTN];

    // Start pulse: rising edge of the debounced level, registered. Not gated
    // by enable so the game can always be (re)started.
    logic start_level;
    logic start_prev_q, start_prev_d;
    logic start_q, start_d;

    assign start_level = deb_all[NUM_IN-1];

    always_comb begin
        start_prev_d = start_level;
        start_d      = start_level & ~start_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            start_q      <= start_d;
        end
    end

    logic [CODE_W-1:0] code_out [2];
    logic              new_out  [2];

    for (genvar g = 0; g < 2; g++) begin : g_player
        player_state_e     state_q, state_d;
        logic [CODE_W-1:0] idx_q, idx_d;
        logic [CODE_W-1:0] code_q, code_d;
        logic              new_q, new_d;
        logic              any_btn;
        logic [CODE_W-1:0] low_idx;

        assign any_btn = |deb_btn[g];
        assign low_idx = lowest_index(7'(deb_btn[g]));

        // Once a code is issued only the latched button can end it; any
        // other buttons still down then force WAIT_REL so codes are always
        // separated by at least one zero cycle.
        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            code_d  = code_q;
            new_d   = 1'b0;
            if (!bus.enable) begin
                state_d = IDLE;
                code_d  = CODE_NONE;
            end else begin
                case (state_q)
                    IDLE: begin
                        code_d = CODE_NONE;
                        if (any_btn) begin
                            idx_d   = low_idx;
                            code_d  = low_idx + CODE_W'(1);
                            new_d   = 1'b1;
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        if (!deb_btn[g][idx_q]) begin
                            code_d  = CODE_NONE;
                            state_d = any_btn ? WAIT_REL : IDLE;
                        end
                    end
                    WAIT_REL: begin
                        code_d = CODE_NONE;
                        if (!any_btn) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        code_d  = CODE_NONE;
                        state_d = IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                idx_q   <= '0;
                code_q  <= CODE_NONE;
                new_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                code_q  <= code_d;
                new_q   <= new_d;
            end
        end

        assign code_out[g] = code_q;
        assign new_out[g]  = new_q;
    end

    assign bus.start  = start_q;
    assign bus.p1     = code_out[0];
    assign bus.p2     = code_out[1];
    assign bus.p1_new = new_out[0];
    assign bus.p2_new = new_out[1];

endmodule

// File: tb/tb_player_input_encoder.sv
// ---------------------------------------------------------------------------
// tb_player_input_encoder
// Directed stimulus with hand-computed expectations, plus a behavioural
// model compared against the DUT outputs on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_player_input_encoder;
    import game_pkg::*;

    localparam int NB  = 5;
    localparam int DEB = 4;
    localparam int NIN = 2 * NB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    player_input_encoder_if #(.NUM_BTN(NB)) bus ();

    player_input_encoder #(
        .NUM_BTN    (NB),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [NIN-1:0] m_s1 = '0;
    logic [NIN-1:0] m_s2 = '0;
    logic [NIN-1:0] m_lvl = '0;
    logic [DEB-1:0] m_hist [NIN];
    logic           m_start_prev = 1'b0;
    logic           m_start = 1'b0;
    int             m_held    [2];
    bit             m_blocked [2];
    int             m_code    [2];
    bit             m_new     [2];
    bit             model_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic st,
                                 input logic [NB-1:0] b1, input logic [NB-1:0] b2);
        bus.enable        = en;
        bus.btn_start_raw = st;
        bus.btn_p1_raw    = b1;
        bus.btn_p2_raw    = b2;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        m_s1 = '0;
        m_s2 = '0;
        m_lvl = '0;
        for (int i = 0; i < NIN; i++) m_hist[i] = '0;
        m_start_prev = 1'b0;
        m_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_held[p] = -1;
            m_blocked[p] = 1'b0;
            m_code[p] = 0;
            m_new[p] = 1'b0;
        end
    endtask

    // A player issues a code for the lowest pressed button, keeps it until
    // that button is released, and then waits for every button to be up.
    task automatic playerStep(input int p, input logic [NB-1:0] btns);
        int low;
        m_new[p] = 1'b0;
        if (!bus.enable) begin
            m_held[p] = -1;
            m_blocked[p] = 1'b0;
            m_code[p] = 0;
        end else if (m_held[p] >= 0) begin
            if (!btns[m_held[p]]) begin
                m_code[p] = 0;
                m_blocked[p] = (btns != '0);
                m_held[p] = -1;
            end
        end else if (m_blocked[p]) begin
            m_code[p] = 0;
            if (btns == '0) m_blocked[p] = 1'b0;
        end else begin
            m_code[p] = 0;
            if (btns != '0) begin
                low = -1;
                for (int b = NB - 1; b >= 0; b--) if (btns[b]) low = b;
                m_held[p] = low;
                m_code[p] = low + 1;
                m_new[p] = 1'b1;
            end
        end
    endtask

    // One clock edge of the model. A debounced level flips when the last DEB
    // synchronized samples all disagree with it.
    task automatic modelStep();
        logic [NIN-1:0] raw, old_s1, old_s2, old_lvl;
        raw = {bus.btn_start_raw, bus.btn_p2_raw, bus.btn_p1_raw};
        if (rst) begin
            modelReset();
            model_valid = 1'b1;
        end else begin
            old_s1 = m_s1;
            old_s2 = m_s2;
            old_lvl = m_lvl;
            playerStep(0, old_lvl[NB-1:0]);
            playerStep(1, old_lvl[2*NB-1:NB]);
            m_start = old_lvl[NIN-1] && !m_start_prev;
            m_start_prev = old_lvl[NIN-1];
            for (int i = 0; i < NIN; i++) begin
                m_hist[i] = {m_hist[i][DEB-2:0], old_s2[i]};
                if (m_hist[i] == {DEB{~old_lvl[i]}}) m_lvl[i] = ~old_lvl[i];
            end
            m_s2 = old_s1;
            m_s1 = raw;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                checkOutput("model_start",  32'(bus.start),  32'(m_start));
                checkOutput("model_p1",     32'(bus.p1),     32'(m_code[0]));
                checkOutput("model_p2",     32'(bus.p2),     32'(m_code[1]));
                checkOutput("model_p1_new", 32'(bus.p1_new), 32'(m_new[0]));
                checkOutput("model_p2_new", 32'(bus.p2_new), 32'(m_new[1]));
            end
        end
    end

    initial begin
        int cnt;
        applyStimulus(1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        waitNeg(3);
        checkOutput("rst_p1", 32'(bus.p1), 0);
        checkOutput("rst_p2", 32'(bus.p2), 0);
        checkOutput("rst_start", 32'(bus.start), 0);
        checkOutput("rst_p1_new", 32'(bus.p1_new), 0);
        checkOutput("rst_p2_new", 32'(bus.p2_new), 0);
        rst = 1'b0;
        waitNeg(5);

        // Clean single press and release on player 1
        applyStimulus(1'b1, 1'b0, 5'b00001, '0);
        waitNeg(6);
        checkOutput("press_early", 32'(bus.p1), 0);
        waitNeg(1);
        checkOutput("press_p1", 32'(bus.p1), 1);
        checkOutput("press_new", 32'(bus.p1_new), 1);
        waitNeg(1);
        checkOutput("press_new_drop", 32'(bus.p1_new), 0);
        checkOutput("press_hold1", 32'(bus.p1), 1);
        waitNeg(10);
        checkOutput("press_hold2", 32'(bus.p1), 1);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(6);
        checkOutput("release_early", 32'(bus.p1), 1);
        waitNeg(1);
        checkOutput("release_p1", 32'(bus.p1), 0);
        waitNeg(5);

        // Bouncing button on player 2
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, '0, (i % 2 == 0) ? 5'b01000 : 5'b00000);
            repeat (2) begin
                waitNeg(1);
                checkOutput("bounce_p2_zero", 32'(bus.p2), 0);
                cnt += int'(bus.p2_new);
            end
        end
        applyStimulus(1'b1, 1'b0, '0, 5'b01000);
        for (int i = 1; i <= 7; i++) begin
            waitNeg(1);
            cnt += int'(bus.p2_new);
            if (i < 7) checkOutput("bounce_settle", 32'(bus.p2), 0);
            else       checkOutput("bounce_p2", 32'(bus.p2), 4);
        end
        repeat (10) begin
            waitNeg(1);
            cnt += int'(bus.p2_new);
        end
        checkOutput("bounce_new_count", 32'(cnt), 1);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(10);

        // Priority, then release of the latched button while another is held
        applyStimulus(1'b1, 1'b0, 5'b11000, '0);
        waitNeg(7);
        checkOutput("prio_p1", 32'(bus.p1), 4);
        checkOutput("prio_new", 32'(bus.p1_new), 1);
        waitNeg(3);
        applyStimulus(1'b1, 1'b0, 5'b10000, '0);
        waitNeg(6);
        checkOutput("prio_still", 32'(bus.p1), 4);
        waitNeg(1);
        checkOutput("waitrel_p1", 32'(bus.p1), 0);
        cnt = 0;
        repeat (10) begin
            waitNeg(1);
            checkOutput("waitrel_hold", 32'(bus.p1), 0);
            cnt += int'(bus.p1_new);
        end
        checkOutput("waitrel_no_new", 32'(cnt), 0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(10);
        applyStimulus(1'b1, 1'b0, 5'b10000, '0);
        waitNeg(7);
        checkOutput("repress_p1", 32'(bus.p1), 5);
        checkOutput("repress_new", 32'(bus.p1_new), 1);
        waitNeg(1);
        checkOutput("repress_new_drop", 32'(bus.p1_new), 0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(10);

        // Enable gating with the button held throughout
        applyStimulus(1'b1, 1'b0, 5'b00001, '0);
        waitNeg(8);
        checkOutput("en_p1", 32'(bus.p1), 1);
        applyStimulus(1'b0, 1'b0, 5'b00001, '0);
        waitNeg(1);
        checkOutput("dis_p1", 32'(bus.p1), 0);
        checkOutput("dis_new", 32'(bus.p1_new), 0);
        waitNeg(3);
        checkOutput("dis_hold", 32'(bus.p1), 0);
        applyStimulus(1'b1, 1'b0, 5'b00001, '0);
        waitNeg(1);
        checkOutput("reen_p1", 32'(bus.p1), 1);
        checkOutput("reen_new", 32'(bus.p1_new), 1);
        waitNeg(1);
        checkOutput("reen_new_drop", 32'(bus.p1_new), 0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(10);

        // Start pulse over a 50-cycle press
        applyStimulus(1'b1, 1'b1, '0, '0);
        waitNeg(6);
        checkOutput("start_early", 32'(bus.start), 0);
        waitNeg(1);
        checkOutput("start_pulse", 32'(bus.start), 1);
        cnt = 0;
        repeat (43) begin
            waitNeg(1);
            cnt += int'(bus.start);
        end
        applyStimulus(1'b1, 1'b0, '0, '0);
        repeat (20) begin
            waitNeg(1);
            cnt += int'(bus.start);
        end
        checkOutput("start_no_repulse", 32'(cnt), 0);

        // Reset while player 2 holds a button
        applyStimulus(1'b1, 1'b0, '0, 5'b00010);
        waitNeg(8);
        checkOutput("mid_p2", 32'(bus.p2), 2);
        rst = 1'b1;
        waitNeg(1);
        checkOutput("mid_rst_p2", 32'(bus.p2), 0);
        checkOutput("mid_rst_p1", 32'(bus.p1), 0);
        checkOutput("mid_rst_start", 32'(bus.start), 0);
        checkOutput("mid_rst_p2_new", 32'(bus.p2_new), 0);
        rst = 1'b0;
        waitNeg(6);
        checkOutput("post_rst_early", 32'(bus.p2), 0);
        waitNeg(1);
        checkOutput("post_rst_p2", 32'(bus.p2), 2);
        checkOutput("post_rst_new", 32'(bus.p2_new), 1);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitNeg(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_input_encoder.md
Name: player_input_encoder

Overview:
- Producer side of the player-code interface consumed by state_machine.
- Converts raw, bouncing player push-buttons and the start button into clean registered signals:
  - per-player 3-bit action codes p1/p2 (0 = no action, 1..NUM_BTN = button index+1);
  - a one-cycle start pulse.
- Sits between board I/O and state_machine; clocked on the same clk.

Parameters:
- NUM_BTN, 5, buttons per player (1..7, so that index+1 fits in 3 bits).
- DEB_CYCLES, 16, consecutive stable synchronized cycles required to accept a level change (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- enable  input  1  1 = accept player actions; 0 = p1/p2 forced to 0, player FSMs held in IDLE
- btn_start_raw  input  1  raw start button, active-high, asynchronous
- btn_p1_raw  input  NUM_BTN  raw player-1 buttons, active-high, asynchronous
- btn_p2_raw  input  NUM_BTN  raw player-2 buttons, active-high, asynchronous
- start  output  1  one-cycle pulse on the debounced start rising edge
- p1  output  3  player-1 action code
- p2  output  3  player-2 action code
- p1_new  output  1  one-cycle pulse in the cycle p1 first shows a new nonzero code
- p2_new  output  1  one-cycle pulse in the cycle p2 first shows a new nonzero code

Behaviour:
- Reset (rst=1 at a clk edge):
  - start, p1, p2, p1_new, p2_new all 0.
  - Synchronizers and debounced levels cleared to 0; all counters 0; player FSMs in IDLE.
  - Reset mid-press: after rst deasserts, a still-held button is treated as a fresh press once debounced.
- Synchronization: every raw input passes through 2 flops before use.
- Debounce, per input:
  - Counter increments while the synchronized value differs from the debounced level.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - Latency from a clean raw change to the debounced change is 2+DEB_CYCLES cycles.
- start:
  - Registered pulse, high for exactly 1 cycle, one cycle after the debounced start level goes 0->1.
  - Not gated by enable. Holding the button never re-pulses.
- Player FSM, one instance per player, states IDLE, HOLD, WAIT_REL:
  - IDLE: if enable and any debounced button is high, latch idx = lowest-index high button, code <= idx+1, new pulse <= 1, go to HOLD. Otherwise code = 0.
  - HOLD: code held. Presses of other buttons are ignored. When debounced button idx falls: code <= 0; go to IDLE if no buttons are high, else go to WAIT_REL.
  - WAIT_REL: code 0; stays until all debounced buttons are 0, then IDLE. This guarantees every code is separated by at least one 0 cycle.
  - enable=0 in any state: code <= 0, state <= IDLE, no new pulse. A button still held when enable returns is accepted on the next IDLE evaluation.
- Output latency: p1/p2 and p*_new are registered, one cycle after the debounced change, so raw edge to code is 3+DEB_CYCLES cycles.
- Simultaneous events:
  - Two buttons debounced in the same cycle: the lowest index wins.
  - Players are fully independent; both new pulses may assert in the same cycle.

Decomposition:
- Shared package (game_pkg) holds:
  - CODE_W=3;
  - CODE_NONE=3'd0;
  - player-FSM state encodings (IDLE=2'd0, HOLD=2'd1, WAIT_REL=2'd2).
- One natural sub-module, btn_debounce:
  - contents: 2-flop synchronizer plus stable-counter (parameter DEB_CYCLES; ports clk, rst, din, dout);
  - instances: 2*NUM_BTN+1 in total.
- Player FSM and priority encode live inline in the top module, generated twice.

Test Plan (DEB_CYCLES=4, NUM_BTN=5):
- Reset, then drive btn_p1_raw=5'b00001 clean at cycle 10 -> p1=1 and p1_new=1 for 1 cycle at cycle 17; p1 stays 1 while held; release -> p1=0 exactly 7 cycles after the release.
- Bounce: toggle btn_p2_raw[3] every 2 cycles for 12 cycles, then hold high -> p2 stays 0 during bouncing; p2=4 appears 7 cycles after the final stable edge; exactly one p2_new pulse.
- Priority and hold:
  - Raise p1 buttons [3] and [4] in the same cycle -> p1=4.
  - Then release [3] while [4] is held -> p1=0 and stays 0 (WAIT_REL), no p1_new.
  - Release [4], then press [4] again -> p1=5 with one p1_new.
- enable gating:
  - enable=0 while p1 button[0] is held -> p1=0 next cycle.
  - Set enable=1 with the button still held -> p1=1 and a p1_new pulse one cycle later.
- Start: press start (clean, 50 cycles) -> exactly one start pulse at cycle press+7; start is 0 for the rest of the hold and after release.
- Reset mid-operation: assert rst while p2=2 is held -> all outputs 0 the next cycle; after rst deasserts with the button still held -> p2=2 after 7 cycles with a p2_new pulse.
